// File: rtl/stream_rr_lzc_arbiter.sv
// Round-robin valid/ready stream arbiter with trailing-zero grant search,
// registered priority pointer and optional grant lock while the output stalls.

module stream_rr_lzc_arbiter #(
   parameter int unsigned NUM_IN     = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter bit          LOCK_IN    = 1'b1,
   parameter int unsigned IDX_WIDTH  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic [NUM_IN-1:0]            inp_valid_i,
   output logic [NUM_IN-1:0]            inp_ready_o,
   input  logic [NUM_IN*DATA_WIDTH-1:0] inp_data_i,
   output logic                         oup_valid_o,
   input  logic                         oup_ready_i,
   output logic [DATA_WIDTH-1:0]        oup_data_o,
   output logic [IDX_WIDTH-1:0]         idx_o
);

   logic [IDX_WIDTH-1:0]  rr_q, rr_d;
   logic                  lock_q, lock_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;

   logic [NUM_IN-1:0]     mask_s;
   logic [NUM_IN-1:0]     masked_s;
   logic [NUM_IN-1:0]     idx_oh_s;
   logic [NUM_IN-1:0]     sel_oh_s;
   logic                  lock_hold_s;
   logic [IDX_WIDTH-1:0]  sel_s;
   logic                  oup_valid_s;
   logic [DATA_WIDTH-1:0] oup_data_s;

   // Index of the lowest set bit; zero when the vector is empty.
   function automatic logic [IDX_WIDTH-1:0] tzc(input logic [NUM_IN-1:0] vec);
      logic [IDX_WIDTH-1:0] pos;
      logic                 found;
      pos   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(NUM_IN); i++) begin
         pos   = (vec[i] && !found) ? IDX_WIDTH'(i) : pos;
         found = found | vec[i];
      end
      return pos;
   endfunction

   // Grant selection: locked index if still requesting, else masked/unmasked search.
   always_comb begin
      mask_s   = '0;
      idx_oh_s = '0;
      for (int i = 0; i < int'(NUM_IN); i++) begin
         mask_s[i]   = (IDX_WIDTH'(i) >= rr_q);
         idx_oh_s[i] = (IDX_WIDTH'(i) == idx_q);
      end
      masked_s    = inp_valid_i & mask_s;
      lock_hold_s = LOCK_IN && lock_q && (|(inp_valid_i & idx_oh_s));
      if (lock_hold_s) begin
         sel_s = idx_q;
      end else if (|masked_s) begin
         sel_s = tzc(masked_s);
      end else begin
         sel_s = tzc(inp_valid_i);
      end
   end

   // Output multiplexer driven by the selected index.
   always_comb begin
      sel_oh_s   = '0;
      oup_data_s = inp_data_i[DATA_WIDTH-1:0];
      for (int i = 0; i < int'(NUM_IN); i++) begin
         sel_oh_s[i] = (IDX_WIDTH'(i) == sel_s);
         oup_data_s  = sel_oh_s[i] ? inp_data_i[i*DATA_WIDTH +: DATA_WIDTH] : oup_data_s;
      end
      oup_valid_s = |(inp_valid_i & sel_oh_s);
   end

   assign oup_valid_o = oup_valid_s;
   assign oup_data_o  = oup_data_s;
   assign idx_o       = sel_s;

   generate
      if (NUM_IN == 1) begin : g_passthrough
         assign inp_ready_o = oup_ready_i;
      end else begin : g_arbitrated
         assign inp_ready_o = sel_oh_s & {NUM_IN{oup_ready_i & oup_valid_s}};
      end
   endgenerate

   // Pointer and lock update; flush wins over any handshake or stall.
   always_comb begin
      rr_d   = rr_q;
      lock_d = lock_q;
      idx_d  = idx_q;
      if (flush_i) begin
         rr_d   = '0;
         lock_d = 1'b0;
      end else if (oup_valid_s && oup_ready_i) begin
         rr_d   = (sel_s == IDX_WIDTH'(NUM_IN - 1)) ? '0 : sel_s + IDX_WIDTH'(1);
         lock_d = 1'b0;
      end else if (oup_valid_s && LOCK_IN) begin
         lock_d = 1'b1;
         idx_d  = sel_s;
      end else begin
         // A stale lock whose input dropped valid is released here.
         lock_d = lock_hold_s;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q   <= '0;
         lock_q <= 1'b0;
         idx_q  <= '0;
      end else begin
         rr_q   <= rr_d;
         lock_q <= lock_d;
         idx_q  <= idx_d;
      end
   end

   stream_rr_lzc_arbiter_checker #(
      .NUM_IN (NUM_IN)
   ) u_checker (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .inp_valid_i (inp_valid_i),
      .inp_ready_o (inp_ready_o)
   );

endmodule

// Protocol monitor: valid must stay up until its handshake; ready is one-hot or zero.
module stream_rr_lzc_arbiter_checker #(
   parameter int unsigned NUM_IN = 4
) (
   input logic              clk_i,
   input logic              rst_ni,
   input logic [NUM_IN-1:0] inp_valid_i,
   input logic [NUM_IN-1:0] inp_ready_o
);

   logic [NUM_IN-1:0] pend_q, pend_d;

   assign pend_d = inp_valid_i & ~inp_ready_o;

   // Requests still outstanding after the previous edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // Edge-sampled protocol checks, quiet while reset is held.
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert ((pend_q & ~inp_valid_i) == '0)
            else $error("arbiter: input dropped valid without handshake (%b)", pend_q & ~inp_valid_i);
         assert ($onehot0(inp_ready_o))
            else $error("arbiter: inp_ready_o not one-hot (%b)", inp_ready_o);
      end
   end

endmodule

// File: tb/tb_stream_rr_lzc_arbiter.sv
// Directed bench for stream_rr_lzc_arbiter: a 4-input and a 3-input instance.

module tb_stream_rr_lzc_arbiter;

   logic        clk;
   logic        rst_ni;
   logic        flush;
   logic [3:0]  valid;
   logic [3:0]  ready_o;
   logic [127:0] data;
   logic        oup_valid;
   logic        oup_ready;
   logic [31:0] oup_data;
   logic [1:0]  idx;

   logic        flush3;
   logic [2:0]  valid3;
   logic [2:0]  ready3_o;
   logic [95:0] data3;
   logic        oup_valid3;
   logic        oup_ready3;
   logic [31:0] oup_data3;
   logic [1:0]  idx3;

   int n_checks;
   int n_fail;

   stream_rr_lzc_arbiter #(.NUM_IN(4), .DATA_WIDTH(32), .LOCK_IN(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
      .inp_valid_i(valid), .inp_ready_o(ready_o), .inp_data_i(data),
      .oup_valid_o(oup_valid), .oup_ready_i(oup_ready), .oup_data_o(oup_data),
      .idx_o(idx)
   );

   stream_rr_lzc_arbiter #(.NUM_IN(3), .DATA_WIDTH(32), .LOCK_IN(1'b1)) dut3 (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush3),
      .inp_valid_i(valid3), .inp_ready_o(ready3_o), .inp_data_i(data3),
      .oup_valid_o(oup_valid3), .oup_ready_i(oup_ready3), .oup_data_o(oup_data3),
      .idx_o(idx3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_ni    = 1'b0;
      flush     = 1'b0;
      valid     = 4'b0000;
      oup_ready = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if (dut.rr_q !== 2'd0 || dut.lock_q !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: rr=%0d lock=%0d, expected 0 0", dut.rr_q, dut.lock_q);
      end
      n_checks++;
      if (oup_valid !== 1'b0 || idx !== 2'd0 || ready_o !== 4'b0000 || oup_data !== 32'hD0D0_0000) begin
         n_fail++; $display("FAIL reset_outputs: v=%b idx=%0d rdy=%b data=%h, expected 0 0 0000 d0d00000",
                            oup_valid, idx, ready_o, oup_data);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_idx;
      logic [3:0]  exp_rdy;
      logic [31:0] exp_data;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         valid     = 4'b1111;
         oup_ready = 1'b1;
         #1;
         exp_idx  = 2'(k % 4);
         exp_rdy  = 4'b0001 << exp_idx;
         exp_data = 32'hD0D0_0000 | 32'(exp_idx);
         n_checks++;
         if (idx !== exp_idx || ready_o !== exp_rdy || oup_valid !== 1'b1 || oup_data !== exp_data) begin
            n_fail++; $display("FAIL rr_cycle%0d: idx=%0d rdy=%b data=%h, expected %0d %b %h",
                               k, idx, ready_o, oup_data, exp_idx, exp_rdy, exp_data);
         end
      end
   endtask

   task automatic test_single_then_pair();
      do_reset();
      @(negedge clk);
      valid = 4'b0100; oup_ready = 1'b1;
      #1;
      n_checks++;
      if (idx !== 2'd2 || ready_o !== 4'b0100 || oup_data !== 32'hD0D0_0002) begin
         n_fail++; $display("FAIL single_in2: idx=%0d rdy=%b data=%h, expected 2 0100 d0d00002", idx, ready_o, oup_data);
      end
      @(negedge clk);
      valid = 4'b1001;
      #1;
      n_checks++;
      if (dut.rr_q !== 2'd3) begin
         n_fail++; $display("FAIL ptr_after_in2: rr=%0d, expected 3", dut.rr_q);
      end
      n_checks++;
      if (idx !== 2'd3 || ready_o !== 4'b1000) begin
         n_fail++; $display("FAIL pair_first: idx=%0d rdy=%b, expected 3 1000", idx, ready_o);
      end
      @(negedge clk);
      valid = 4'b0001;
      #1;
      n_checks++;
      if (idx !== 2'd0 || ready_o !== 4'b0001) begin
         n_fail++; $display("FAIL pair_second: idx=%0d rdy=%b, expected 0 0001", idx, ready_o);
      end
   endtask

   task automatic test_lock_stall();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         valid = (k == 0) ? 4'b0010 : 4'b0011;
         oup_ready = 1'b0;
         #1;
         n_checks++;
         if (idx !== 2'd1 || oup_data !== 32'hD0D0_0001 || oup_valid !== 1'b1 || ready_o !== 4'b0000) begin
            n_fail++; $display("FAIL stall_cycle%0d: idx=%0d data=%h rdy=%b, expected 1 d0d00001 0000",
                               k, idx, oup_data, ready_o);
         end
      end
      @(negedge clk);
      oup_ready = 1'b1;
      #1;
      n_checks++;
      if (idx !== 2'd1 || ready_o !== 4'b0010) begin
         n_fail++; $display("FAIL stall_release: idx=%0d rdy=%b, expected 1 0010", idx, ready_o);
      end
      @(negedge clk);
      valid = 4'b0001;
      #1;
      n_checks++;
      if (idx !== 2'd0 || ready_o !== 4'b0001 || oup_data !== 32'hD0D0_0000) begin
         n_fail++; $display("FAIL stall_wrap: idx=%0d rdy=%b data=%h, expected 0 0001 d0d00000", idx, ready_o, oup_data);
      end
   endtask

   task automatic test_flush_lock();
      do_reset();
      @(negedge clk);
      valid = 4'b0100; oup_ready = 1'b1;
      @(negedge clk);
      valid = 4'b1010; oup_ready = 1'b0;
      #1;
      n_checks++;
      if (idx !== 2'd3) begin
         n_fail++; $display("FAIL flush_pre: idx=%0d, expected 3", idx);
      end
      @(negedge clk);
      flush = 1'b1;
      #1;
      n_checks++;
      if (idx !== 2'd3 || dut.lock_q !== 1'b1) begin
         n_fail++; $display("FAIL flush_locked: idx=%0d lock=%0d, expected 3 1", idx, dut.lock_q);
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      n_checks++;
      if (idx !== 2'd1 || dut.lock_q !== 1'b0 || dut.rr_q !== 2'd0) begin
         n_fail++; $display("FAIL flush_after: idx=%0d lock=%0d rr=%0d, expected 1 0 0", idx, dut.lock_q, dut.rr_q);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      @(negedge clk);
      valid = 4'b0010; oup_ready = 1'b1;
      @(negedge clk);
      valid = 4'b1010; oup_ready = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if (dut.rr_q !== 2'd2 || dut.lock_q !== 1'b1 || idx !== 2'd3) begin
         n_fail++; $display("FAIL areset_pre: rr=%0d lock=%0d idx=%0d, expected 2 1 3", dut.rr_q, dut.lock_q, idx);
      end
      #1;
      rst_ni = 1'b0;
      #1;
      n_checks++;
      if (dut.rr_q !== 2'd0 || dut.lock_q !== 1'b0 || idx !== 2'd1) begin
         n_fail++; $display("FAIL areset_now: rr=%0d lock=%0d idx=%0d, expected 0 0 1", dut.rr_q, dut.lock_q, idx);
      end
      valid = 4'b1111; oup_ready = 1'b1;
      @(negedge clk);
      rst_ni = 1'b1;
      #1;
      n_checks++;
      if (idx !== 2'd0 || ready_o !== 4'b0001) begin
         n_fail++; $display("FAIL areset_after: idx=%0d rdy=%b, expected 0 0001", idx, ready_o);
      end
      do_reset();
   endtask

   task automatic test_three_inputs();
      @(negedge clk);
      valid3 = 3'b000; oup_ready3 = 1'b1;
      #1;
      n_checks++;
      if (oup_valid3 !== 1'b0 || idx3 !== 2'd0 || ready3_o !== 3'b000) begin
         n_fail++; $display("FAIL n3_idle: v=%b idx=%0d rdy=%b, expected 0 0 000", oup_valid3, idx3, ready3_o);
      end
      @(negedge clk);
      valid3 = 3'b100;
      #1;
      n_checks++;
      if (oup_valid3 !== 1'b1 || idx3 !== 2'd2 || ready3_o !== 3'b100 || oup_data3 !== 32'hC3C3_0002) begin
         n_fail++; $display("FAIL n3_in2: v=%b idx=%0d rdy=%b data=%h, expected 1 2 100 c3c30002",
                            oup_valid3, idx3, ready3_o, oup_data3);
      end
      @(negedge clk);
      valid3 = 3'b011;
      #1;
      n_checks++;
      if (dut3.rr_q !== 2'd0) begin
         n_fail++; $display("FAIL n3_wrap: rr=%0d, expected 0", dut3.rr_q);
      end
      n_checks++;
      if (idx3 !== 2'd0 || ready3_o !== 3'b001) begin
         n_fail++; $display("FAIL n3_next: idx=%0d rdy=%b, expected 0 001", idx3, ready3_o);
      end
      @(negedge clk);
      valid3 = 3'b010;
      #1;
      n_checks++;
      if (idx3 !== 2'd1 || ready3_o !== 3'b010) begin
         n_fail++; $display("FAIL n3_last: idx=%0d rdy=%b, expected 1 010", idx3, ready3_o);
      end
      @(negedge clk);
      valid3 = 3'b000;
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_ni     = 1'b0;
      flush      = 1'b0;
      valid      = 4'b0000;
      oup_ready  = 1'b0;
      data       = {32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000};
      flush3     = 1'b0;
      valid3     = 3'b000;
      oup_ready3 = 1'b0;
      data3      = {32'hC3C3_0002, 32'hC3C3_0001, 32'hC3C3_0000};
      test_reset();
      test_round_robin();
      test_single_then_pair();
      test_lock_stall();
      test_flush_lock();
      test_async_reset();
      test_three_inputs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
